timer_sched: RTL and testbench



---
 rtl/timer_sched_pkg.sv | 42 ++++
 rtl/timer_sched_if.sv | 27 ++
 rtl/timer_sched_timer.sv | 39 +++
 rtl/timer_sched.sv | 169 ++++++++++++++++
 tb/tb_timer_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types, constants and the round-robin picker for the timer scheduler.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_e;

    // The shared hardware timer always counts 8-cycle periods.
    localparam int TIMER_PERIOD = 8;
    localparam int TIMER_W      = $clog2(TIMER_PERIOD);

    // Widest supported requester vector; the picker works on this width so one
    // function serves every NUM_REQ setting.
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    // First set bit of req, searching upward from ptr and wrapping at num.
    // Returns 0 when nothing is set (callers only use it when some bit is set).
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int                 num
    );
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % num;
            if ((k < num) && !found && req[idx[PTR_W-1:0]]) begin
                pick  = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/timer_sched_if.sv
// Requester-side bus of the timer scheduler: requests in, grant/done status out.
interface timer_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int REP_W   = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*REP_W-1:0] req_reps;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [ID_W-1:0]          active_id;

    // Requesters drive req/req_reps and observe the scheduler status.
    modport master (
        output req, req_reps,
        input  grant, done, busy, active_id
    );

    // The scheduler consumes requests and drives the status.
    modport slave (
        input  req, req_reps,
        output grant, done, busy, active_id
    );

endinterface

// File: rtl/timer_sched_timer.sv
// Shared 8-cycle delay timer. Counts while enabled and parks at 0 when idle,
// so a disabled timer sitting on its last count still returns to 0.
module timer_sched_timer
    import timer_sched_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               en_i,
    output logic               ready_o,
    output logic [TIMER_W-1:0] count_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMER_PERIOD - 1);

    logic [TIMER_W-1:0] count_q, count_d;

    // Next count: advance (wrapping) when enabled, otherwise hold except at LAST.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + TIMER_W'(1);
        end else if (count_q == LAST) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign ready_o = (count_q == LAST);
    assign count_o = count_q;

endmodule

// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one 8-cycle timer between NUM_REQ requesters.
// The owner keeps the timer for a latched number of periods; withdrawing the
// request aborts, but the timer is still run to its wrap so the next owner
// always starts from count 0.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REP_W   = 4
) (
    input  logic         clk,
    input  logic         resetn,
    timer_sched_if.slave bus
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DONE  = 2'(DONE);
    localparam logic [1:0] S_ABORT = 2'(ABORT);

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               en_q, en_d;

    logic               tmr_ready;
    logic [TIMER_W-1:0] tmr_count;

    logic [MAX_REQ-1:0] req_ext;
    logic [PTR_W-1:0]   pick;
    logic [ID_W-1:0]    id_pick;
    logic [REP_W-1:0]   reps_sel;
    logic [ID_W-1:0]    ptr_next;
    logic               req_own;

    timer_sched_timer u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (en_q),
        .ready_o (tmr_ready),
        .count_o (tmr_count)
    );

    // Candidate owner for the next grant and the owner's hand-over pointer.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = bus.req;
        pick                   = rr_pick(req_ext, PTR_W'(rr_ptr_q), NUM_REQ);
        id_pick                = ID_W'(pick);
        reps_sel               = bus.req_reps[int'(id_pick)*REP_W +: REP_W];
        req_own                = bus.req[id_q];
        if (int'(id_q) == NUM_REQ - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = id_q + ID_W'(1);
        end
    end

    // Next-state logic for the scheduler FSM and its registered outputs.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        reps_d   = reps_q;
        en_d     = en_q;
        grant_d  = '0;
        done_d   = '0;
        busy_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d = S_RUN;
                    id_d    = id_pick;
                    reps_d  = (reps_sel == '0) ? REP_W'(1) : reps_sel;
                    en_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (tmr_ready) begin
                    // Final period wins over a simultaneous withdrawal.
                    reps_d = reps_q - REP_W'(1);
                    if (reps_q <= REP_W'(1)) begin
                        state_d  = S_DONE;
                        en_d     = 1'b0;
                        rr_ptr_d = ptr_next;
                    end else if (!req_own) begin
                        // Count wraps on this edge, so nothing left to drain.
                        state_d  = S_ABORT;
                        en_d     = 1'b0;
                        rr_ptr_d = ptr_next;
                    end
                end else if (!req_own) begin
                    state_d  = S_ABORT;
                    en_d     = 1'b1;
                    rr_ptr_d = ptr_next;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                // Drain the timer to its wrap before releasing it.
                if (!en_q || tmr_ready) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase

        if (state_d == S_RUN) begin
            grant_d[id_d] = 1'b1;
        end
        if (state_d == S_DONE) begin
            done_d[id_d] = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Scheduler state and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            rr_ptr_q <= '0;
            reps_q   <= '0;
            en_q     <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            reps_q   <= reps_d;
            en_q     <= en_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.active_id = id_q;

    // The timer must be parked at 0 whenever nobody owns it.
    ap_idle_no_ready: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == S_IDLE) |-> !tmr_ready);

    // Every new owner starts from a clean count.
    ap_grant_count_zero: assert property (@(posedge clk) disable iff (!resetn)
        ((state_q == S_RUN) && ($past(state_q) == S_IDLE)) |-> (tmr_count == '0));

    ap_grant_onehot: assert property (@(posedge clk) disable iff (!resetn)
        $onehot0(grant_q));

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: table of single-owner transactions, then hand-written
// reset, round-robin, abort and late-drop sequences. A monitor pops expected
// {owner, grant-to-done latency} records whenever a done pulse appears.
module tb_timer_sched;

    localparam int NUM_REQ = 4;
    localparam int REP_W   = 4;

    typedef struct {
        int         id;
        logic [3:0] reps;
        int         exp_lat;
    } vec_t;

    typedef struct {
        int id;
        int lat;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    exp_t sbq[$];
    exp_t mon_e;
    int   grant_start = 0;
    logic [NUM_REQ-1:0] prev_grant = '0;

    timer_sched_if #(.NUM_REQ(NUM_REQ), .REP_W(REP_W)) bus ();

    timer_sched #(.NUM_REQ(NUM_REQ), .REP_W(REP_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Done-pulse monitor: pops the scoreboard and checks owner and latency.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_grant = '0;
        end else begin
            if ((bus.grant != '0) && (prev_grant == '0)) grant_start = cyc;
            if (bus.done != '0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", int'(bus.done), 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("done_id", int'(bus.done), 1 << mon_e.id);
                    check("done_latency", cyc - grant_start, mon_e.lat);
                    check("grant_before_done", int'(prev_grant), 1 << mon_e.id);
                    check("grant_at_done", int'(bus.grant), 0);
                end
            end
            prev_grant = bus.grant;
        end
    end

    task automatic set_reps(input int id, input logic [3:0] r);
        bus.req_reps[id*REP_W +: REP_W] = r;
    endtask

    task automatic wait_grant(output int c);
        c = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_idle(output int c);
        c = -1;
        for (int k = 0; k < 400; k++) begin
            if (!bus.busy) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
        if (c < 0) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   gc, dc, ic, gc2, prev_dc, other;

        vt[0] = '{0, 4'd1,   8};
        vt[1] = '{2, 4'd3,  24};
        vt[2] = '{1, 4'd0,   8};
        vt[3] = '{3, 4'd15, 120};
        vt[4] = '{0, 4'd2,  16};
        vt[5] = '{3, 4'd1,   8};

        bus.req      = '0;
        bus.req_reps = '0;
        resetn       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_active_id", int'(bus.active_id), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);

        // Table of single-owner transactions
        for (int i = 0; i < 6; i++) begin
            wait_idle(ic);
            @(negedge clk);
            set_reps(vt[i].id, vt[i].reps);
            bus.req[vt[i].id] = 1'b1;
            sbq.push_back('{vt[i].id, vt[i].exp_lat});
            wait_grant(gc);
            check("vec_active_id", int'(bus.active_id), vt[i].id);
            check("vec_busy_run", int'(bus.busy), 1);
            // Late reps change and a brief foreign request must not matter.
            set_reps(vt[i].id, 4'(i + 5));
            other = (vt[i].id + 1) % NUM_REQ;
            @(negedge clk);
            bus.req[other] = 1'b1;
            repeat (2) @(negedge clk);
            bus.req[other] = 1'b0;
            wait_done(dc);
            bus.req[vt[i].id] = 1'b0;
            @(negedge clk);
            check("vec_done_width", int'(bus.done), 0);
            check("vec_busy_after", int'(bus.busy), 0);
        end

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        set_reps(1, 4'd4);
        bus.req[1] = 1'b1;
        wait_grant(gc);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_grant", int'(bus.grant), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_active_id", int'(bus.active_id), 0);
        check("arst_count", int'(dut.u_timer.count_q), 0);
        bus.req = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        set_reps(3, 4'd1);
        bus.req[3] = 1'b1;
        sbq.push_back('{3, 8});
        wait_grant(gc);
        check("arst_next_id", int'(bus.active_id), 3);
        wait_done(dc);
        bus.req[3] = 1'b0;

        // Round-robin contention, every requester held with one period
        @(negedge clk);
        bus.req_reps = 16'h1111;
        bus.req      = 4'b1111;
        sbq.push_back('{0, 8});
        sbq.push_back('{1, 8});
        sbq.push_back('{2, 8});
        sbq.push_back('{3, 8});
        sbq.push_back('{0, 8});
        prev_dc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_done(dc);
            if (k > 0) check("rr_done_spacing", dc - prev_dc, 10);
            prev_dc = dc;
        end
        bus.req = '0;

        // Abort three cycles after grant; timer drains before the next grant
        wait_idle(ic);
        @(negedge clk);
        set_reps(1, 4'd2);
        bus.req[1] = 1'b1;
        wait_grant(gc);
        check("abort_start_count", int'(dut.u_timer.count_q), 0);
        repeat (3) @(negedge clk);
        bus.req[1] = 1'b0;
        set_reps(2, 4'd1);
        bus.req[2] = 1'b1;
        sbq.push_back('{2, 8});
        @(negedge clk);
        check("abort_grant_drop", int'(bus.grant), 0);
        check("abort_busy", int'(bus.busy), 1);
        wait_idle(ic);
        check("abort_idle_cycle", ic - gc, 8);
        wait_grant(gc2);
        check("abort_next_gap", gc2 - ic, 1);
        check("abort_next_id", int'(bus.active_id), 2);
        check("abort_next_count", int'(dut.u_timer.count_q), 0);
        wait_done(dc);
        bus.req[2] = 1'b0;

        // Withdrawal on the final ready cycle still completes
        @(negedge clk);
        set_reps(0, 4'd2);
        bus.req[0] = 1'b1;
        sbq.push_back('{0, 16});
        wait_grant(gc);
        repeat (15) @(negedge clk);
        check("late_final_count", int'(dut.u_timer.count_q), 7);
        bus.req[0] = 1'b0;
        wait_done(dc);
        check("late_done_cycle", dc - gc, 16);
        @(negedge clk);
        check("late_busy_after", int'(bus.busy), 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
